// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter, one bit per clock
//
// Converts an N_BIN-bit binary value into N_DIG packed BCD digits using shift-add-3.
// A conversion is accepted from IDLE when i_start=1. It takes N_BIN SHIFT cycles and one
// DONE cycle. o_valid pulses one cycle after DONE.
//
// Parameters:
//   N_BIN     width of the binary input (>= 2)
//   N_DIG     number of BCD digits; o_bcd is 4*N_DIG bits wide
//
// Optional build macro:
//   BIN2BCD_SIGNED_EN  i_bin is two's complement. Its magnitude is converted and the
//                      sign is reported on o_neg.
//
// Ports:
//   i_clock   system clock, rising edge
//   i_reset   synchronous active-high reset
//   i_start   conversion request, sampled only while idle
//   i_bin     binary value, captured on the accepting edge
//   o_bcd     packed BCD result, digit 0 (units) in [3:0]; held between conversions
//   o_valid   one-cycle pulse when o_bcd/o_ovf are updated
//   o_busy    high while a conversion is in progress
//   o_ovf     value did not fit in N_DIG digits (o_bcd holds value mod 10^N_DIG)
//   o_neg     (signed build only) sign of the converted value

module bin2bcd_seq #(
    parameter int N_BIN = 16,
    parameter int N_DIG = 5
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [N_BIN-1:0]     i_bin,
    output logic [4*N_DIG-1:0]   o_bcd,
    output logic                 o_valid,
    output logic                 o_busy,
    output logic                 o_ovf
`ifdef BIN2BCD_SIGNED_EN
    ,
    output logic                 o_neg
`endif
);

    localparam int W  = 4 * N_DIG;
    localparam int CW = $clog2(N_BIN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [N_BIN-1:0]    r_shift;
    logic [W-1:0]        r_scratch;
    logic                r_acc;
    logic [CW-1:0]       r_cnt;
    logic [W-1:0]        r_bcd;
    logic                r_ovf;
    logic                r_valid;
    logic [W-1:0]        w_corr;
    logic [N_BIN-1:0]    w_load;
    logic                w_busy;
`ifdef BIN2BCD_SIGNED_EN
    logic                r_sign;
    logic                r_neg;
`endif

    // Value loaded into the shift register on the accepting edge. In the signed build the
    // magnitude of -2^(N_BIN-1) is 2^(N_BIN-1), which still fits as an unsigned N_BIN value.
`ifdef BIN2BCD_SIGNED_EN
    assign w_load = i_bin[N_BIN-1] ? (~i_bin + {{(N_BIN-1){1'b0}}, 1'b1}) : i_bin;
`else
    assign w_load = i_bin;
`endif

    // Add-3 correction on every digit >= 5, applied to all digits in parallel before the shift.
    always_comb begin
        w_corr = r_scratch;
        for (int i = 0; i < N_DIG; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_corr[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next_state = S_SHIFT;
            S_SHIFT: if (r_cnt == CW'(1)) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    // Datapath
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_acc     <= 1'b0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_valid   <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            r_sign    <= 1'b0;
            r_neg     <= 1'b0;
`endif
        end else begin
            r_valid <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_shift   <= w_load;
                        r_scratch <= '0;
                        r_acc     <= 1'b0;
                        r_cnt     <= CW'(N_BIN);
`ifdef BIN2BCD_SIGNED_EN
                        r_sign    <= i_bin[N_BIN-1];
`endif
                    end
                end
                S_SHIFT: begin
                    // {scratch, shift} << 1; the bit leaving the top digit marks overflow.
                    r_scratch <= {w_corr[W-2:0], r_shift[N_BIN-1]};
                    r_shift   <= {r_shift[N_BIN-2:0], 1'b0};
                    r_acc     <= r_acc | w_corr[W-1];
                    r_cnt     <= r_cnt - CW'(1);
                end
                S_DONE: begin
                    r_bcd <= r_scratch;
                    r_ovf <= r_acc;
`ifdef BIN2BCD_SIGNED_EN
                    r_neg <= r_sign;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign o_bcd   = r_bcd;
    assign o_valid = r_valid;
    assign o_busy  = w_busy;
    assign o_ovf   = r_ovf;
`ifdef BIN2BCD_SIGNED_EN
    assign o_neg   = r_neg;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq (16/5 and 8/2 instances)

module tb_bin2bcd_seq;

    logic        clk;
    logic        i_reset;
    logic        i_start;
    logic [15:0] i_bin;
    logic [19:0] o_bcd;
    logic        o_valid;
    logic        o_busy;
    logic        o_ovf;
    logic        o_neg_w;

    logic        s_start;
    logic [7:0]  s_bin;
    logic [7:0]  s_bcd;
    logic        s_valid;
    logic        s_busy;
    logic        s_ovf;
    logic        s_neg_w;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bin2bcd_seq #(.N_BIN(16), .N_DIG(5)) dut (
        .i_clock (clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_bin   (i_bin),
        .o_bcd   (o_bcd),
        .o_valid (o_valid),
        .o_busy  (o_busy),
        .o_ovf   (o_ovf)
`ifdef BIN2BCD_SIGNED_EN
        ,
        .o_neg   (o_neg_w)
`endif
    );

    bin2bcd_seq #(.N_BIN(8), .N_DIG(2)) dut_small (
        .i_clock (clk),
        .i_reset (i_reset),
        .i_start (s_start),
        .i_bin   (s_bin),
        .o_bcd   (s_bcd),
        .o_valid (s_valid),
        .o_busy  (s_busy),
        .o_ovf   (s_ovf)
`ifdef BIN2BCD_SIGNED_EN
        ,
        .o_neg   (s_neg_w)
`endif
    );

`ifndef BIN2BCD_SIGNED_EN
    assign o_neg_w = 1'b0;
    assign s_neg_w = 1'b0;
`endif

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic check_digits(input string name, input logic [19:0] bcd);
        logic [19:0] b;
        b = bcd;
        for (int d = 0; d < 5; d++) begin
            check(name, 64'(b[4*d +: 4] <= 4'd9), 64'd1);
        end
    endtask

    // Pulse i_start for one accepted edge, then watch the cycles that follow.
    // n counts cycles after the accepting edge (n=0 is the cycle right after it).
    task automatic conv(input logic [15:0] bin, output logic [19:0] bcd, output logic ovf,
                        output logic neg, output int lat, output int busy_n);
        @(negedge clk);
        i_bin   = bin;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_bin   = ~bin;
        lat     = -1;
        busy_n  = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (o_busy) busy_n++;
            if (o_valid) begin
                lat = n;
                break;
            end
        end
        bcd = o_bcd;
        ovf = o_ovf;
        neg = o_neg_w;
        @(negedge clk);
        check("valid_one_cycle", 64'(o_valid), 64'd0);
    endtask

    task automatic sconv(input logic [7:0] bin, output logic [7:0] bcd, output logic ovf,
                         output logic neg, output int lat);
        @(negedge clk);
        s_bin   = bin;
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        lat     = -1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (s_valid) begin
                lat = n;
                break;
            end
        end
        bcd = s_bcd;
        ovf = s_ovf;
        neg = s_neg_w;
    endtask

    initial begin
        logic [19:0] bcd;
        logic [7:0]  sb;
        logic        ovf;
        logic        neg;
        int          lat;
        int          busy_n;
        int          vcount;
        int          vfirst;
        int          vsecond;

        vecs[0]  = '{16'd0,     20'h00000, 1'b0};
        vecs[1]  = '{16'd1,     20'h00001, 1'b0};
        vecs[2]  = '{16'd9,     20'h00009, 1'b0};
        vecs[3]  = '{16'd10,    20'h00010, 1'b0};
        vecs[4]  = '{16'd99,    20'h00099, 1'b0};
        vecs[5]  = '{16'd100,   20'h00100, 1'b0};
        vecs[6]  = '{16'd12345, 20'h12345, 1'b0};
        vecs[7]  = '{16'd4321,  20'h04321, 1'b0};
        vecs[8]  = '{16'd999,   20'h00999, 1'b0};
        vecs[9]  = '{16'd10000, 20'h10000, 1'b0};
        vecs[10] = '{16'd32767, 20'h32767, 1'b0};
        vecs[11] = '{16'd9999,  20'h09999, 1'b0};

        i_reset = 1'b1;
        i_start = 1'b0;
        i_bin   = 16'd0;
        s_start = 1'b0;
        s_bin   = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_bcd",   64'(o_bcd),   64'd0);
        check("reset_valid", 64'(o_valid), 64'd0);
        check("reset_busy",  64'(o_busy),  64'd0);
        check("reset_ovf",   64'(o_ovf),   64'd0);
        check("reset_neg",   64'(o_neg_w), 64'd0);
        i_reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            conv(vecs[i].bin, bcd, ovf, neg, lat, busy_n);
            check($sformatf("vec%0d_bcd", i),     64'(bcd),    64'(vecs[i].bcd));
            check($sformatf("vec%0d_ovf", i),     64'(ovf),    64'(vecs[i].ovf));
            check($sformatf("vec%0d_neg", i),     64'(neg),    64'd0);
            check($sformatf("vec%0d_latency", i), 64'(lat),    64'd17);
            check($sformatf("vec%0d_busy", i),    64'(busy_n), 64'd17);
            check_digits($sformatf("vec%0d_digit_le9", i), bcd);
        end

        repeat (20) @(negedge clk);
        check("hold_bcd",   64'(o_bcd),  64'h09999);
        check("hold_busy",  64'(o_busy), 64'd0);

        // Back-to-back with i_start held high: 12345 then 65535, valids 18 cycles apart.
        @(negedge clk);
        i_bin   = 16'd12345;
        i_start = 1'b1;
        @(posedge clk);
        vfirst  = -1;
        vsecond = -1;
        for (int n = 0; n < 45; n++) begin
            @(negedge clk);
            if (n == 0) i_bin = 16'd65535;
            if (o_valid && vfirst < 0) begin
                vfirst = n;
                check("b2b_first_bcd", 64'(o_bcd), 64'h12345);
            end else if (o_valid && vsecond < 0) begin
                vsecond = n;
                i_start = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
                check("b2b_second_bcd", 64'(o_bcd), 64'h00001);
                check("b2b_second_neg", 64'(o_neg_w), 64'd1);
`else
                check("b2b_second_bcd", 64'(o_bcd), 64'h65535);
`endif
            end
        end
        i_start = 1'b0;
        check("b2b_first_at",  64'(vfirst),  64'd17);
        check("b2b_spacing",   64'(vsecond - vfirst), 64'd18);
        repeat (25) @(negedge clk);

        // Requests while busy are ignored and i_bin is not re-sampled.
        @(negedge clk);
        i_bin   = 16'd999;
        i_start = 1'b1;
        @(posedge clk);
        vcount = 0;
        for (int n = 0; n < 45; n++) begin
            @(negedge clk);
            i_start = (n == 3 || n == 10);
            if (n == 0) i_bin = 16'd1;
            if (o_valid) begin
                vcount++;
                check("ignore_bcd", 64'(o_bcd), 64'h00999);
            end
        end
        i_start = 1'b0;
        check("ignore_single_result", 64'(vcount), 64'd1);

        // Reset 5 cycles into a conversion aborts it without a result.
        @(negedge clk);
        i_bin   = 16'd4321;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (4) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        check("abort_busy",  64'(o_busy),  64'd0);
        check("abort_bcd",   64'(o_bcd),   64'd0);
        check("abort_valid", 64'(o_valid), 64'd0);
        i_reset = 1'b0;
        vcount  = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (o_valid) vcount++;
        end
        check("abort_no_valid", 64'(vcount), 64'd0);
        conv(16'd4321, bcd, ovf, neg, lat, busy_n);
        check("after_abort_bcd",     64'(bcd), 64'h04321);
        check("after_abort_latency", 64'(lat), 64'd17);

`ifdef BIN2BCD_SIGNED_EN
        conv(16'hFFFF, bcd, ovf, neg, lat, busy_n);
        check("signed_m1_bcd", 64'(bcd), 64'h00001);
        check("signed_m1_neg", 64'(neg), 64'd1);
        conv(16'h8000, bcd, ovf, neg, lat, busy_n);
        check("signed_min_bcd", 64'(bcd), 64'h32768);
        check("signed_min_neg", 64'(neg), 64'd1);
        check("signed_min_ovf", 64'(ovf), 64'd0);
`else
        conv(16'd65535, bcd, ovf, neg, lat, busy_n);
        check("max_bcd", 64'(bcd), 64'h65535);
        check("max_ovf", 64'(ovf), 64'd0);
        conv(16'd50000, bcd, ovf, neg, lat, busy_n);
        check("u50000_bcd", 64'(bcd), 64'h50000);
`endif

        // 8-bit / 2-digit instance: overflow wraps to value mod 100.
        sconv(8'd255, sb, ovf, neg, lat);
        check("small_latency", 64'(lat), 64'd9);
`ifdef BIN2BCD_SIGNED_EN
        check("small_m1_bcd", 64'(sb),  64'h01);
        check("small_m1_neg", 64'(neg), 64'd1);
        check("small_m1_ovf", 64'(ovf), 64'd0);
`else
        check("small_255_bcd", 64'(sb),  64'h55);
        check("small_255_ovf", 64'(ovf), 64'd1);
`endif
        sconv(8'd99, sb, ovf, neg, lat);
        check("small_99_bcd", 64'(sb),  64'h99);
        check("small_99_ovf", 64'(ovf), 64'd0);
        sconv(8'd100, sb, ovf, neg, lat);
        check("small_100_bcd", 64'(sb),  64'h00);
        check("small_100_ovf", 64'(ovf), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using the iterative double-dabble (shift-add-3) method, one bit per clock.
- Sits directly upstream of the 7-segment decoders: the packed BCD output feeds the per-digit hex-to-segment decoders nibble by nibble.
- Replaces wide lookup-table decimal conversion for measurement values (counts, frequencies, duty) too wide to tabulate.

Parameters:
- N_BIN, 16, width of the unsigned binary input.
- N_DIG, 5, number of BCD digits produced. Output width is 4*N_DIG.

Ports:
- i_clock  in  1  system clock, all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  conversion request; sampled only when o_busy=0.
- i_bin  in  N_BIN  binary value, captured on the accepting edge only.
- o_bcd  out  4*N_DIG  packed BCD, digit 0 (units) in [3:0], digit k in [4k+3:4k]; registered and held between conversions.
- o_valid  out  1  one-cycle pulse when o_bcd is updated.
- o_busy  out  1  high while a conversion is in progress.
- o_ovf  out  1  high if the value did not fit in N_DIG digits; updated together with o_bcd.

Behaviour:
- Interface: one clock (i_clock); reset is synchronous and active-high (i_reset).
- Reset values: o_bcd=0, o_valid=0, o_busy=0, o_ovf=0, state=IDLE, internal shift, scratch and counter registers cleared.
- Reset mid-conversion: abort immediately and return to IDLE. o_bcd is cleared and no o_valid pulse is issued.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, with i_start=1 at edge k:
  - capture i_bin into the shift register;
  - clear the BCD scratch and overflow accumulator;
  - load the bit counter with N_BIN;
  - go to SHIFT, with o_busy=1 from the cycle after edge k.
- SHIFT, each edge:
  - every scratch digit >=5 gets +3 (all digits corrected in parallel, combinationally);
  - then {scratch, shift} is shifted left 1;
  - the bit leaving the top of the scratch is ORed into the overflow accumulator;
  - the counter decrements.
  - After N_BIN SHIFT edges (edges k+1..k+N_BIN), go to DONE.
- DONE, edge k+N_BIN+1:
  - o_bcd<=scratch, o_ovf<=accumulator, o_valid<=1 for exactly one cycle;
  - o_busy<=0; go to IDLE.
- Latency: o_valid is high in the cycle following edge k+N_BIN+1, i.e. N_BIN+2 cycles after the accepting edge.
- i_start while o_busy=1 is ignored: no queueing, and i_bin is not re-sampled.
- i_start high in the same cycle as o_valid is accepted (FSM is already IDLE). Back-to-back throughput is one result per N_BIN+2 cycles.
- i_start held high continuously gives repeated conversions with a fresh i_bin capture each time.
- Digit width rule: every scratch digit is 4 bits; after correction and shift each digit is always <=9 (invariant checked in the bench).
- Overflow: if 10^N_DIG <= 2^N_BIN-1, large inputs set o_ovf=1. o_bcd then holds the low N_DIG decimal digits, i.e. value mod 10^N_DIG.
- o_bcd holds its last value indefinitely while IDLE.

Optional Feature:
- Macro: BIN2BCD_SIGNED_EN.
- Defined:
  - i_bin is two's complement;
  - the magnitude (-i_bin when MSB=1) is loaded on the accepting edge;
  - extra output o_neg (1 bit, reset 0) is updated with o_bcd and set to the captured sign;
  - -2^(N_BIN-1) converts to magnitude 2^(N_BIN-1) with no overflow of the shift register.
- Not defined: o_neg port is absent and i_bin is unsigned.
- Timing and FSM are identical in both builds.

Test Plan:
- Defaults, i_bin=0, pulse i_start -> o_busy high for 17 cycles, o_valid one cycle at start+18, o_bcd=20'h00000, o_ovf=0.
- i_bin=12345 then i_bin=65535 back-to-back (i_start held high) -> o_bcd=20'h12345, then 20'h65535, o_valid pulses 18 cycles apart.
- i_bin=999, then i_start pulsed at cycles 3 and 10 after accept with i_bin changed to 1 -> single result 20'h00999, second request ignored.
- N_BIN=8, N_DIG=2, i_bin=255 -> o_bcd=8'h55, o_ovf=1. Then i_bin=99 -> o_bcd=8'h99, o_ovf=0.
- i_reset asserted 5 cycles into a conversion of 4321 -> next cycle o_busy=0, o_bcd=0, no o_valid. A new start then yields 20'h04321.
- BIN2BCD_SIGNED_EN, N_BIN=16: i_bin=-1 -> o_bcd=20'h00001, o_neg=1. i_bin=16'h8000 -> o_bcd=20'h32768, o_neg=1, o_ovf=0.
